fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle fetch controller that owns the PC register and sequences next-PC selection: sequential (+4), branch, j/jal and jr.
- Issues one instruction-memory request at a time using a req/rvalid handshake, and presents each fetched instruction downstream on a valid/ready handshake.
- Flushes or drains in-flight fetches when decode signals a redirect.
- Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- PC_W, 32, PC and data width; fixed at 32 in this design.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_rvalid.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_rvalid  in  1  read data valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word.
- out_valid  out  1  held instruction available.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  32  held instruction.
- out_pc  out  32  address of the held instruction.
- redir_branch  in  1  taken-branch redirect pulse.
- redir_jump  in  1  j/jal redirect pulse.
- redir_jr  in  1  jr redirect pulse.
- redir_base_pc  in  32  PC of the redirecting instruction.
- redir_imm32  in  32  sign-extended branch offset, in words.
- redir_index  in  26  j/jal instr_index field.
- redir_jr_addr  in  32  register target for jr.
- addr_err  out  1  sticky: a misaligned redirect target was seen.
- delivered_cnt  out  32  count of completed out handshakes.

Behaviour:
- Reset (asynchronous, reset_n=0): state=S_IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, out_valid=0, out_instr=0, out_pc=0, addr_err=0, delivered_cnt=0. Reset asserted mid-fetch abandons the request immediately.
- Redirect target (combinational):
  - branch: base_pc + 4 + (imm32<<2), modulo 2^32.
  - jump: {base_pc[31:28], index, 2'b00}.
  - jr: jr_addr.
  - Priority when several redirect inputs are high: branch > jump > jr.
  - If target[1:0] != 0: bits [1:0] are forced to 0 and addr_err is set; it stays set until reset.
- States:
  - S_IDLE: imem_req=0. Next cycle go to S_REQ, with imem_addr<=pc.
  - S_REQ: imem_req=1. rvalid may arrive in the same cycle as req (zero-wait memory).
    - On rvalid with no redirect: out_instr<=rdata, out_pc<=imem_addr, out_valid<=1, pc<=imem_addr+4; go to S_HOLD.
  - S_HOLD: imem_req=0, out_valid=1.
    - On out_ready: out_valid<=0, delivered_cnt++ (wraps at 2^32), imem_addr<=pc; go to S_REQ.
  - S_DRAIN: imem_req=1 with the old imem_addr unchanged. On rvalid, discard the data, imem_addr<=pc; go to S_REQ.
- Redirect handling, per state (pc<=target in every case):
  - S_IDLE: go to S_REQ with imem_addr<=target.
  - S_REQ without rvalid: go to S_DRAIN.
  - S_REQ with rvalid in the same cycle: discard the data, imem_addr<=target, stay in S_REQ.
  - S_HOLD with out_ready=1: the handshake completes and is counted; go to S_REQ at target.
  - S_HOLD with out_ready=0: the held instruction is flushed (out_valid<=0, not counted); go to S_REQ at target.
  - S_DRAIN: pc<=latest target; the most recent redirect wins.
- Throughput: at most one instruction per 2 cycles; no overlapping requests.
- imem_addr never changes while imem_req=1.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (S_IDLE, S_REQ, S_HOLD, S_DRAIN);
  - the RESET_PC default;
  - the redirect-kind enum (RD_NONE, RD_BR, RD_J, RD_JR);
  - the priority encoding function.
- One sub-module, redirect_target_calc: combinational priority select plus target arithmetic plus misalignment flag.

Test Plan:
- Reset behaviour: reset_n low for 3 cycles, then high; memory is zero-wait and returns 0x2408_0001. Required:
  - cycle 1 after release: imem_req=0;
  - cycle 2: imem_req=1, imem_addr=0x3000;
  - next cycle: out_valid=1, out_pc=0x3000, out_instr=0x2408_0001.
- Backpressure: out_ready=0 for 5 cycles. Required: out_valid, out_instr and out_pc held stable, imem_req=0, delivered_cnt unchanged. Then out_ready=1 for 1 cycle. Required: delivered_cnt=1, next imem_addr=0x3004.
- Drain: memory with 3-cycle latency; pulse redir_jump with index=0x0000C10 and base_pc=0x3000 while in S_REQ. Required: imem_addr stays 0x3004 until rvalid, that data is never presented, next request goes to 0x0000_3040.
- Redirect priority: redir_branch=1 and redir_jr=1 together, base_pc=0x3008, imm32=0xFFFF_FFFE, jr_addr=0x4000. Required: next fetch at 0x3004 (the branch wins).
- Misaligned jr: redir_jr_addr=0x3013. Required: fetch at 0x3010, addr_err=1, still 1 after 10 further fetches.
- Reset mid-fetch: reset_n low while imem_req=1 in S_DRAIN. Required: imem_req=0 and out_valid=0 immediately (asynchronous); after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch sequencer: FSM states, redirect kinds
// and the redirect priority encoder.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_J,
    RD_JR
  } redir_kind_t;

  // Branch beats jump beats jr when several redirect pulses coincide.
  function automatic redir_kind_t redir_priority(input logic branch,
                                                 input logic jump,
                                                 input logic jr);
    redir_kind_t kind;
    if (branch)    kind = RD_BR;
    else if (jump) kind = RD_J;
    else if (jr)   kind = RD_JR;
    else           kind = RD_NONE;
    return kind;
  endfunction

endpackage

// File: rtl/redirect_target_calc.sv
// Combinational redirect target: priority select, target arithmetic and
// word-alignment check.
module redirect_target_calc
  import fetch_pkg::*;
(
  input  logic        redir_branch,
  input  logic        redir_jump,
  input  logic        redir_jr,
  input  logic [31:0] redir_base_pc,
  input  logic [31:0] redir_imm32,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_jr_addr,
  output logic        redir_valid,
  output logic [31:0] target,
  output logic        misaligned
);

  redir_kind_t kind;
  logic [31:0] raw_target;

  always_comb begin
    kind       = redir_priority(redir_branch, redir_jump, redir_jr);
    raw_target = '0;
    case (kind)
      RD_BR:   raw_target = redir_base_pc + 32'd4 + {redir_imm32[29:0], 2'b00};
      RD_J:    raw_target = {redir_base_pc[31:28], redir_index, 2'b00};
      RD_JR:   raw_target = redir_jr_addr;
      default: raw_target = '0;
    endcase
    redir_valid = (kind != RD_NONE);
    // A misaligned target is rounded down to the word so fetch can proceed.
    target      = {raw_target[31:2], 2'b00};
    misaligned  = redir_valid && (raw_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, issues one imem request at a time
// and hands each instruction to decode, flushing or draining on redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            redir_branch,
  input  logic            redir_jump,
  input  logic            redir_jr,
  input  logic [PC_W-1:0] redir_base_pc,
  input  logic [PC_W-1:0] redir_imm32,
  input  logic [25:0]     redir_index,
  input  logic [PC_W-1:0] redir_jr_addr,
  output logic            addr_err,
  output logic [31:0]     delivered_cnt
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [PC_W-1:0] addr_next;
  logic            valid_next;
  logic            capture;
  logic            count;
  logic            redir_valid;
  logic            misaligned;
  logic [PC_W-1:0] target;

  redirect_target_calc u_target (
    .redir_branch  (redir_branch),
    .redir_jump    (redir_jump),
    .redir_jr      (redir_jr),
    .redir_base_pc (redir_base_pc),
    .redir_imm32   (redir_imm32),
    .redir_index   (redir_index),
    .redir_jr_addr (redir_jr_addr),
    .redir_valid   (redir_valid),
    .target        (target),
    .misaligned    (misaligned)
  );

  assign imem_req = (state == S_REQ) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      imem_addr     <= RESET_PC;
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      addr_err      <= 1'b0;
      delivered_cnt <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      imem_addr <= addr_next;
      out_valid <= valid_next;
      if (capture) begin
        out_instr <= imem_rdata;
        out_pc    <= imem_addr;
      end
      if (misaligned) addr_err <= 1'b1;
      if (count) delivered_cnt <= delivered_cnt + 32'd1;
    end
  end

  // imem_addr only moves on transitions into S_REQ, so it is stable while
  // imem_req is high; a redirect always retargets pc, whatever the state.
  always_comb begin
    state_next = state;
    pc_next    = redir_valid ? target : pc;
    addr_next  = imem_addr;
    valid_next = out_valid;
    capture    = 1'b0;
    count      = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_REQ;
        addr_next  = redir_valid ? target : pc;
      end
      S_REQ: begin
        if (redir_valid) begin
          if (imem_rvalid) addr_next  = target;
          else             state_next = S_DRAIN;
        end else if (imem_rvalid) begin
          capture    = 1'b1;
          valid_next = 1'b1;
          pc_next    = imem_addr + 32'd4;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready || redir_valid) begin
          valid_next = 1'b0;
          count      = out_ready;
          state_next = S_REQ;
          addr_next  = redir_valid ? target : pc;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_next = S_REQ;
          addr_next  = redir_valid ? target : pc;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: variable-latency memory model plus
// a scoreboard of expected (pc, instr) deliveries.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redir_branch;
  logic        redir_jump;
  logic        redir_jr;
  logic [31:0] redir_base_pc;
  logic [31:0] redir_imm32;
  logic [25:0] redir_index;
  logic [31:0] redir_jr_addr;
  logic        addr_err;
  logic [31:0] delivered_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   test_cnt = 0;
  int   fail_cnt = 0;
  logic [3:0] latency;
  logic [3:0] wait_cnt;
  bit   seen;

  fetch_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redir_branch  (redir_branch),
    .redir_jump    (redir_jump),
    .redir_jr      (redir_jr),
    .redir_base_pc (redir_base_pc),
    .redir_imm32   (redir_imm32),
    .redir_index   (redir_index),
    .redir_jr_addr (redir_jr_addr),
    .addr_err      (addr_err),
    .delivered_cnt (delivered_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory answers after `latency` waiting cycles; latency 0 is zero-wait.
  assign imem_rvalid = imem_req && (wait_cnt >= latency);
  assign imem_rdata  = mem_word(imem_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     wait_cnt <= '0;
    else if (imem_req && !imem_rvalid) wait_cnt <= wait_cnt + 4'd1;
    else                              wait_cnt <= '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr);
    exp_t e;
    e.pc    = addr;
    e.instr = mem_word(addr);
    exp_q.push_back(e);
  endtask

  task automatic wait_delivered(input string tag, input logic [31:0] target,
                                input int budget);
    for (int i = 0; i < budget && delivered_cnt != target; i++) tick();
    checkOutput(tag, delivered_cnt, target);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_pc", out_pc, mon_e.pc);
        checkOutput("sb_instr", out_instr, mon_e.instr);
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    out_ready     = 1'b0;
    redir_branch  = 1'b0;
    redir_jump    = 1'b0;
    redir_jr      = 1'b0;
    redir_base_pc = '0;
    redir_imm32   = '0;
    redir_index   = '0;
    redir_jr_addr = '0;
    latency       = 4'd0;
    repeat (3) tick();
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h3000);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pc", out_pc, 32'd0);
    checkOutput("rst_instr", out_instr, 32'd0);
    checkOutput("rst_err", 32'(addr_err), 32'd0);
    checkOutput("rst_cnt", delivered_cnt, 32'd0);

    reset_n = 1'b1;
    #1;
    checkOutput("rel_c1_req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("rel_c2_req", 32'(imem_req), 32'd1);
    checkOutput("rel_c2_addr", imem_addr, 32'h3000);
    applyStimulus(32'h3000);
    tick();
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_pc", out_pc, 32'h3000);
    checkOutput("first_instr", out_instr, 32'h2408_0001);

    repeat (5) begin
      tick();
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_pc", out_pc, 32'h3000);
      checkOutput("bp_instr", out_instr, 32'h2408_0001);
      checkOutput("bp_req", 32'(imem_req), 32'd0);
      checkOutput("bp_cnt", delivered_cnt, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_done_cnt", delivered_cnt, 32'd1);
    checkOutput("bp_next_addr", imem_addr, 32'h3004);
    checkOutput("bp_next_req", 32'(imem_req), 32'd1);

    latency       = 4'd3;
    redir_jump    = 1'b1;
    redir_base_pc = 32'h3000;
    redir_index   = 26'h000_0C10;
    tick();
    redir_jump = 1'b0;
    checkOutput("drain_req", 32'(imem_req), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      checkOutput("drain_addr", imem_addr, 32'h3004);
      checkOutput("drain_novalid", 32'(out_valid), 32'd0);
      if (imem_rvalid) seen = 1'b1;
      tick();
    end
    checkOutput("drain_rvalid_seen", 32'(seen), 32'd1);
    checkOutput("drain_next_addr", imem_addr, 32'h3040);
    checkOutput("drain_next_req", 32'(imem_req), 32'd1);
    checkOutput("drain_novalid2", 32'(out_valid), 32'd0);
    checkOutput("drain_cnt", delivered_cnt, 32'd1);
    applyStimulus(32'h3040);
    wait_delivered("drain_deliver", 32'd2, 20);

    latency = 4'd0;
    checkOutput("seq_addr", imem_addr, 32'h3044);
    redir_branch  = 1'b1;
    redir_jr      = 1'b1;
    redir_base_pc = 32'h3008;
    redir_imm32   = 32'hFFFF_FFFE;
    redir_jr_addr = 32'h4000;
    tick();
    redir_branch = 1'b0;
    redir_jr     = 1'b0;
    checkOutput("prio_addr", imem_addr, 32'h3004);
    checkOutput("prio_err", 32'(addr_err), 32'd0);
    checkOutput("prio_novalid", 32'(out_valid), 32'd0);
    checkOutput("prio_cnt", delivered_cnt, 32'd2);
    applyStimulus(32'h3004);
    wait_delivered("prio_deliver", 32'd3, 20);

    redir_jr      = 1'b1;
    redir_jr_addr = 32'h3013;
    tick();
    redir_jr = 1'b0;
    checkOutput("mis_addr", imem_addr, 32'h3010);
    checkOutput("mis_err", 32'(addr_err), 32'd1);
    for (int k = 0; k < 11; k++) applyStimulus(32'h3010 + 32'(4 * k));
    wait_delivered("mis_deliver", 32'd14, 80);
    checkOutput("mis_err_sticky", 32'(addr_err), 32'd1);
    checkOutput("mis_sb_empty", 32'(exp_q.size()), 32'd0);

    latency = 4'd3;
    checkOutput("pre_rst_addr", imem_addr, 32'h303C);
    redir_jump    = 1'b1;
    redir_base_pc = 32'h3000;
    redir_index   = 26'h000_0C10;
    tick();
    redir_jump = 1'b0;
    checkOutput("mid_drain_req", 32'(imem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'd0);
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_cnt", delivered_cnt, 32'd0);
    checkOutput("async_addr", imem_addr, 32'h3000);
    tick();
    tick();
    latency = 4'd0;
    reset_n = 1'b1;
    tick();
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h3000);
    checkOutput("restart_err", 32'(addr_err), 32'd0);
    applyStimulus(32'h3000);
    wait_delivered("restart_deliver", 32'd1, 20);
    checkOutput("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
